// File: rtl/adc_calc_param_bank.sv
// adc_calc_param_bank
//   Bank of NUM_CH single-precision gain/offset pairs for the ADC scaling
//   pipeline. Software writes shadow registers over AXI4-Lite. A COMMIT copies
//   every shadow value to the active outputs on one clock edge, then the new
//   set is streamed out over AXI4-Stream, one channel per beat.
//
//   Optional feature macro: CALC_PARAM_READBACK_EN
//     defined   : shadow gain/offset words read back their current value
//     undefined : shadow words are write-only and read as 0
//
// Ports
//   s00_axi_aclk / s00_axi_aresetn : clock, asynchronous active-low reset
//   s00_axi_*                      : AXI4-Lite slave (AW/W/B/AR/R)
//   o_gain / o_offset              : active values, channel k at [32k+31:32k]
//   m_axis_tdata                   : {offset, gain} of the channel in flight
//   m_axis_tuser                   : channel index of the current beat
//   m_axis_tlast                   : marks channel NUM_CH-1
//   m_axis_tvalid / m_axis_tready  : stream handshake
//
// Word map: 0 CTRL (bit0 COMMIT, bit1 RESTORE, write-1 pulses, reads 0)
//           1 STATUS (bit0 BUSY, bit1 OVERRUN W1C, bits[15:8] COMMIT_CNT)
//           2+2k shadow gain k, 3+2k shadow offset k

module adc_calc_param_bank #(
    parameter int          NUM_CH             = 20,
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = $clog2(2*NUM_CH+2)+2,
    parameter logic [31:0] DEF_GAIN           = 32'h35A0_0000,
    parameter logic [31:0] DEF_OFFSET         = 32'hC120_0000
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic [32*NUM_CH-1:0]              o_gain,
    output logic [32*NUM_CH-1:0]              o_offset,
    output logic [63:0]                       m_axis_tdata,
    output logic [4:0]                        m_axis_tuser,
    output logic                              m_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready
);

    localparam int WORD_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam int IDX_W  = 5;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;

    logic [31:0]        shadow_gain   [NUM_CH];
    logic [31:0]        shadow_offset [NUM_CH];
    logic [31:0]        active_gain   [NUM_CH];
    logic [31:0]        active_offset [NUM_CH];

    logic               overrun;
    logic [7:0]         commit_cnt;

    logic [WORD_W-1:0]  wr_word, rd_word;
    logic               wr_en, rd_en;
    logic               ctrl_wr, commit_req, restore_req;
    logic               commit_go, overrun_set, overrun_clr;
    logic               busy, stream_fire, last_fire;
    logic [31:0]        status_word, rd_mux;

    // Address LSBs, protection bits and byte strobes carry no meaning here:
    // every access is a full 32-bit word.
    logic               unused_bits;
    assign unused_bits = ^{s00_axi_awaddr[1:0], s00_axi_araddr[1:0],
                           s00_axi_awprot, s00_axi_arprot, s00_axi_wstrb};

    assign wr_word = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_word = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];

    assign wr_en = s00_axi_awready & s00_axi_awvalid & s00_axi_wready & s00_axi_wvalid;
    assign rd_en = s00_axi_arready & s00_axi_arvalid;

    assign busy        = (state == SEND);
    assign ctrl_wr     = wr_en && (wr_word == '0);
    assign commit_req  = ctrl_wr & s00_axi_wdata[0];
    assign restore_req = ctrl_wr & s00_axi_wdata[1];
    assign commit_go   = commit_req & ~busy;
    assign overrun_set = commit_req &  busy;
    assign overrun_clr = wr_en && (wr_word == WORD_W'(1)) && s00_axi_wdata[1];

    assign stream_fire = m_axis_tvalid & m_axis_tready;
    assign last_fire   = stream_fire && (idx == LAST_IDX);

    assign status_word = {16'h0000, commit_cnt, 6'b000000, overrun, busy};

    assign s00_axi_bresp = 2'b00;
    assign s00_axi_rresp = 2'b00;

    // AXI4-Lite handshakes: ready pulses for one cycle, response holds until taken
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
        end else begin
            // The ~awready term stops a second accept in the cycle the
            // handshake completes, before bvalid has risen.
            s00_axi_awready <= s00_axi_awvalid & s00_axi_wvalid & ~s00_axi_bvalid & ~s00_axi_awready;
            s00_axi_wready  <= s00_axi_awvalid & s00_axi_wvalid & ~s00_axi_bvalid & ~s00_axi_awready;
            if (wr_en)
                s00_axi_bvalid <= 1'b1;
            else if (s00_axi_bready)
                s00_axi_bvalid <= 1'b0;

            s00_axi_arready <= s00_axi_arvalid & ~s00_axi_rvalid & ~s00_axi_arready;
            if (rd_en) begin
                s00_axi_rvalid <= 1'b1;
                s00_axi_rdata  <= rd_mux;
            end else if (s00_axi_rready) begin
                s00_axi_rvalid <= 1'b0;
            end
        end
    end

    // Read mux; CTRL and anything out of range read as 0
    always_comb begin
        rd_mux = '0;
        if (rd_word == WORD_W'(1))
            rd_mux = status_word;
`ifdef CALC_PARAM_READBACK_EN
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd_word == WORD_W'(2 + 2*k)) rd_mux = shadow_gain[k];
            if (rd_word == WORD_W'(3 + 2*k)) rd_mux = shadow_offset[k];
        end
`endif
    end

    // Shadow and active banks. On COMMIT+RESTORE the defaults go straight to
    // the active bank, since the shadow copy only lands on this same edge.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            for (int k = 0; k < NUM_CH; k++) begin
                shadow_gain[k]   <= DEF_GAIN;
                shadow_offset[k] <= DEF_OFFSET;
                active_gain[k]   <= DEF_GAIN;
                active_offset[k] <= DEF_OFFSET;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (restore_req) begin
                    shadow_gain[k]   <= DEF_GAIN;
                    shadow_offset[k] <= DEF_OFFSET;
                end else if (wr_en && (wr_word == WORD_W'(2 + 2*k))) begin
                    shadow_gain[k]   <= s00_axi_wdata[31:0];
                end else if (wr_en && (wr_word == WORD_W'(3 + 2*k))) begin
                    shadow_offset[k] <= s00_axi_wdata[31:0];
                end

                if (commit_go) begin
                    active_gain[k]   <= restore_req ? DEF_GAIN   : shadow_gain[k];
                    active_offset[k] <= restore_req ? DEF_OFFSET : shadow_offset[k];
                end
            end
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            overrun    <= 1'b0;
            commit_cnt <= 8'h00;
        end else begin
            if (overrun_set)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;
            if (last_fire)
                commit_cnt <= commit_cnt + 8'h01;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_pack
            assign o_gain[32*g +: 32]   = active_gain[g];
            assign o_offset[32*g +: 32] = active_offset[g];
        end
    endgenerate

    // Stream FSM: state register
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Stream FSM: next state
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (commit_go) begin
                    state_nxt = SEND;
                    idx_nxt   = '0;
                end
            end
            SEND: begin
                if (last_fire) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else if (stream_fire) begin
                    idx_nxt = idx + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // Stream FSM: outputs. Decoded from state so tvalid falls with the
    // asynchronous reset rather than one clock later.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = '0;
        m_axis_tdata  = '0;
        if (state == SEND) begin
            m_axis_tvalid = 1'b1;
            m_axis_tuser  = idx;
            m_axis_tlast  = (idx == LAST_IDX);
            for (int k = 0; k < NUM_CH; k++) begin
                if (idx == IDX_W'(k))
                    m_axis_tdata = {active_offset[k], active_gain[k]};
            end
        end
    end

endmodule
